// File: rtl/soft_ext_trig_stamp_pkg.sv
// soft_ext_trig_stamp shared types.
// Event record is {trignum, time}, trignum in the MSBs.
package soft_ext_trig_stamp_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DEAD = 1'b1
  } state_e;

  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int evt_w(
    input int tn_w,
    input int ts_w
  );
    return tn_w + ts_w;
  endfunction

endpackage

// File: rtl/soft_ext_trig_stamp_fifo.sv
// First-word-fall-through event FIFO.
// Push while full is refused on pre-edge occupancy.
module trig_evt_fifo
  import soft_ext_trig_stamp_pkg::*;
#(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/soft_ext_trig_stamp.sv
// Trigger qualifier with deadtime, numbering and timestamping.
// Events are queued in a small FWFT FIFO for the event builder.
module soft_ext_trig_stamp
  import soft_ext_trig_stamp_pkg::*;
#(
  parameter int TS_W  = 32,
  parameter int TN_W  = 16,
  parameter int DT_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk250_i,
  input  logic            rst_n_i,
  input  logic            trig_i,
  input  logic            enable_i,
  input  logic            clear_i,
  input  logic [DT_W-1:0] deadtime_i,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [TN_W-1:0] evt_trignum_o,
  output logic [TS_W-1:0] evt_time_o,
  output logic            busy_o,
  output logic            overflow_o,
  output logic [15:0]     drop_count_o
);

  localparam int EW = evt_w(TN_W, TS_W);

  state_e              state;
  logic [DT_W-1:0]     dcnt;
  logic [TS_W-1:0]     ts;
  logic [TN_W-1:0]     tn;
  logic [DROP_W-1:0]   drop;
  logic                ovf;
  logic                full;
  logic                empty;
  logic                qual;
  logic                push;
  logic                pop;
  logic [EW-1:0]       head;

  // clear wins over a coincident trigger
  assign qual = trig_i & enable_i & ~clear_i &
                (state == S_IDLE);
  assign push = qual & ~full;
  assign pop  = ~empty & evt_ready_i;

  trig_evt_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk250_i),
    .rst_n (rst_n_i),
    .clr   (clear_i),
    .push  (push),
    .pop   (pop),
    .din   ({tn, ts}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
      dcnt  <= '0;
    end else if (clear_i) begin
      state <= S_IDLE;
      dcnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (qual && deadtime_i != '0) begin
            state <= S_DEAD;
            dcnt  <= deadtime_i;
          end
        end
        S_DEAD: begin
          dcnt <= dcnt - DT_W'(1);
          if (dcnt == DT_W'(1))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ts   <= '0;
      tn   <= '0;
      drop <= '0;
      ovf  <= 1'b0;
    end else if (clear_i) begin
      ts   <= '0;
      tn   <= '0;
      drop <= '0;
      ovf  <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (push)
        tn <= tn + TN_W'(1);
      if (qual && full) begin
        ovf <= 1'b1;
        if (drop != DROP_MAX)
          drop <= drop + DROP_W'(1);
      end
    end
  end

  assign evt_valid_o  = ~empty;
  assign {evt_trignum_o, evt_time_o} = empty ? '0 : head;
  assign busy_o       = (state == S_DEAD);
  assign overflow_o   = ovf;
  assign drop_count_o = drop;

endmodule

// File: tb/tb_soft_ext_trig_stamp.sv
// Scoreboard bench for soft_ext_trig_stamp.
// Model tracks holdoff by cycle index and events by queue.
module tb_soft_ext_trig_stamp;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic        en;
  logic        clr;
  logic [15:0] dead;
  logic        ready;
  logic        valid;
  logic [15:0] tn_o;
  logic [31:0] time_o;
  logic        busy;
  logic        ovf;
  logic [15:0] drop;

  soft_ext_trig_stamp #(
    .TS_W  (32),
    .TN_W  (16),
    .DT_W  (16),
    .DEPTH (DEPTH)
  ) dut (
    .clk250_i      (clk),
    .rst_n_i       (rst_n),
    .trig_i        (trig),
    .enable_i      (en),
    .clear_i       (clr),
    .deadtime_i    (dead),
    .evt_valid_o   (valid),
    .evt_ready_i   (ready),
    .evt_trignum_o (tn_o),
    .evt_time_o    (time_o),
    .busy_o        (busy),
    .overflow_o    (ovf),
    .drop_count_o  (drop)
  );

  typedef struct packed {
    logic [15:0] tn;
    logic [31:0] ts;
  } ev_t;

  ev_t         exp_q[$];
  int          checks;
  int          failures;
  longint      cyc;
  longint      ready_at;
  logic [31:0] m_ts;
  logic [15:0] m_tn;
  logic [15:0] m_drop;
  logic        m_ovf;
  int          m_occ;

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cyc      = 0;
    ready_at = 0;
    m_ts     = '0;
    m_tn     = '0;
    m_drop   = '0;
    m_ovf    = 1'b0;
    m_occ    = 0;
  endtask

  // reference model: applies the rules at each active edge
  always @(posedge clk) begin
    if (rst_n) begin
      bit do_pop;
      do_pop = (m_occ > 0) && ready;
      if (clr) begin
        exp_q.delete();
        m_ts     = '0;
        m_tn     = '0;
        m_drop   = '0;
        m_ovf    = 1'b0;
        m_occ    = 0;
        ready_at = cyc + 1;
      end else begin
        if (trig && en && cyc >= ready_at) begin
          if (m_occ < DEPTH) begin
            exp_q.push_back('{tn: m_tn, ts: m_ts});
            m_tn  = m_tn + 16'd1;
            m_occ = m_occ + 1;
          end else begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF)
              m_drop = m_drop + 16'd1;
          end
          ready_at = cyc + longint'(dead) + 1;
        end
        if (do_pop)
          m_occ = m_occ - 1;
        m_ts = m_ts + 32'd1;
      end
      cyc = cyc + 1;
    end
  end

  // monitor: compares DUT outputs mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 64'(valid), 64'(m_occ > 0));
      chk("busy", 64'(busy), 64'(cyc < ready_at));
      chk("drop", 64'(drop), 64'(m_drop));
      chk("ovf", 64'(ovf), 64'(m_ovf));
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("evt_unexpected", 64'(1), 64'(0));
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("evt_tn", 64'(tn_o), 64'(e.tn));
          chk("evt_time", 64'(time_o), 64'(e.ts));
        end
      end
    end
  end

  task automatic step(input bit t, input bit e,
                      input bit c, input bit r,
                      input logic [15:0] d);
    trig  = t;
    en    = e;
    clr   = c;
    ready = r;
    dead  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    trig = 0; en = 0; clr = 0; ready = 0; dead = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_tn", 64'(tn_o), 64'(0));
    chk("rst_time", 64'(time_o), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_drop", 64'(drop), 64'(0));
    do_reset();

    // first trigger at timestamp 10
    repeat (10) step(0, 1, 0, 0, 16'd0);
    step(1, 1, 0, 0, 16'd0);
    chk("p1_valid", 64'(valid), 64'(1));
    chk("p1_tn", 64'(tn_o), 64'(0));
    chk("p1_time", 64'(time_o), 64'(10));
    step(0, 1, 0, 1, 16'd0);

    // deadtime 5, trigger every cycle
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) n++;
      step(1, 1, 0, 1, 16'd5);
    end
    chk("p2_busy_cycles", 64'(n), 64'(16));
    repeat (6) step(0, 1, 0, 1, 16'd5);
    step(1, 1, 0, 0, 16'd0);
    chk("p2_next_tn", 64'(tn_o), 64'(5));
    step(0, 1, 0, 1, 16'd0);

    // overflow with a stalled consumer
    step(0, 1, 1, 0, 16'd0);
    repeat (6) step(1, 1, 0, 0, 16'd0);
    chk("p3_drop", 64'(drop), 64'(2));
    chk("p3_ovf", 64'(ovf), 64'(1));
    chk("p3_head_tn", 64'(tn_o), 64'(0));
    repeat (4) step(0, 1, 0, 1, 16'd0);
    chk("p3_drained", 64'(valid), 64'(0));
    step(1, 1, 0, 0, 16'd0);
    chk("p3_next_tn", 64'(tn_o), 64'(4));
    step(0, 1, 0, 1, 16'd0);

    // trigger while full coincident with a pop
    repeat (4) step(1, 1, 0, 0, 16'd0);
    step(1, 1, 0, 1, 16'd0);
    chk("p4_drop", 64'(drop), 64'(3));
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid) n++;
      step(0, 1, 0, 1, 16'd0);
    end
    chk("p4_occupancy", 64'(n), 64'(3));

    // clear beats a coincident trigger
    repeat (2) step(1, 1, 0, 0, 16'd0);
    step(1, 1, 1, 0, 16'd3);
    chk("p5_valid", 64'(valid), 64'(0));
    chk("p5_drop", 64'(drop), 64'(0));
    chk("p5_ovf", 64'(ovf), 64'(0));
    chk("p5_busy", 64'(busy), 64'(0));
    step(1, 1, 0, 0, 16'd0);
    chk("p5_tn", 64'(tn_o), 64'(0));
    chk("p5_time", 64'(time_o), 64'(0));
    step(0, 1, 0, 1, 16'd0);

    // disabled triggers are ignored
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1, 16'd5);
      chk("p6_busy", 64'(busy), 64'(0));
      chk("p6_valid", 64'(valid), 64'(0));
    end
    chk("p6_drop", 64'(drop), 64'(0));

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 9) < 6),
           16'($urandom_range(0, 7)));
    end

    // async reset in DEAD with events queued
    step(0, 1, 1, 0, 16'd0);
    step(1, 1, 0, 0, 16'd20);
    repeat (3) step(0, 1, 0, 0, 16'd20);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_valid", 64'(valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_tn", 64'(tn_o), 64'(0));
    chk("mid_rst_time", 64'(time_o), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 1, 0, 0, 16'd0);
    chk("post_rst_time", 64'(time_o), 64'(0));
    repeat (3) step(0, 1, 0, 1, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soft_ext_trig_stamp.md
# soft_ext_trig_stamp

Consumes the single-cycle 250 MHz soft/external trigger pulse and turns it into numbered, timestamped trigger events for the readout. Applies a programmable deadtime after each qualified trigger and buffers events in a small FIFO drained by a valid/ready handshake. Sits directly downstream of the soft-or-external trigger pipe, in the clk250 domain, feeding the event-building logic.

## Interface
- TS_W, 32: timestamp counter width
- TN_W, 16: trigger number width
- DT_W, 16: deadtime register width
- DEPTH, 4: event FIFO depth (power of 2, ≥2)

- clk250_i  in  1  system 250 MHz clock; the only clock
- rst_n_i  in  1  asynchronous, active-low reset
- trig_i  in  1  single-cycle trigger pulse from the soft/ext trigger pipe
- enable_i  in  1  trigger qualification enable
- clear_i  in  1  synchronous clear of counters, FIFO, flags
- deadtime_i  in  DT_W  holdoff length in clk250 cycles, sampled on acceptance
- evt_valid_o  out  1  event available at FIFO head
- evt_ready_i  in  1  consumer accepts head event when high with evt_valid_o
- evt_trignum_o  out  TN_W  trigger number of head event
- evt_time_o  out  TS_W  timestamp of head event
- busy_o  out  1  high while in DEAD
- overflow_o  out  1  sticky: a qualified trigger was dropped (FIFO full)
- drop_count_o  out  16  dropped-trigger count, saturating at 0xFFFF

## Operation
- Timestamp counter: +1 every cycle, wraps modulo 2^TS_W; 0 after reset/clear.
- Qualified trigger: trig_i && enable_i while FSM in IDLE. trig_i with enable_i low, or in DEAD, is ignored (no count, no drop).
- FSM states IDLE, DEAD.
  - IDLE, qualified trigger, deadtime_i≠0 -> DEAD, down-counter loaded with deadtime_i.
  - IDLE, qualified trigger, deadtime_i=0 -> stay IDLE.
  - DEAD: counter decrements each cycle; on reaching 1 -> IDLE at next edge.
- On qualified trigger: if FIFO not full, push {trignum, timestamp}, trignum +1 (wraps modulo 2^TN_W); if full, drop: drop_count +1 (saturating), overflow_o set, trignum not advanced. Deadtime applies in both cases.
- Full is evaluated on occupancy before the edge: push while full is dropped even if a pop occurs that same cycle.
- Pop on evt_valid_o && evt_ready_i. evt_* outputs hold stable while valid and not ready.
- clear_i: FSM -> IDLE, FIFO flushed, trignum, timestamp, drop_count, overflow -> 0. clear_i has priority over a coincident trigger, which is discarded.
- Reset values: evt_valid_o 0, evt_trignum_o 0, evt_time_o 0, busy_o 0, overflow_o 0, drop_count_o 0; FSM IDLE.

## Timing
- Trigger at cycle N (IDLE) captures the timestamp value present during cycle N; evt_valid_o high from cycle N+1 when FIFO was empty.
- Deadtime D≥1: busy_o high cycles N+1..N+D; next trigger accepted earliest at N+D+1. D=0: back-to-back triggers every cycle accepted.
- Pop at cycle M: next head (if any) visible at M+1; no bubble.
- deadtime_i changes during DEAD do not affect the running holdoff.
- Reset asserted mid-DEAD or with FIFO occupied: all state immediately to reset values; deassertion takes effect at next clk250_i edge.

## Structure
- Shared package: state enum (IDLE, DEAD), event record width TN_W+TS_W, packing order {trignum, time} (trignum in MSBs).
- One sub-module: trig_evt_fifo, synchronous first-word-fall-through FIFO, DEPTH entries, full/empty flags, async active-low reset.

## Test plan
- Reset release, enable_i=1, deadtime_i=0, trig_i at cycle where timestamp=10 -> evt_valid_o next cycle, trignum 0, time 10.
- deadtime_i=5, triggers every cycle for 20 cycles, consumer always ready -> events at timestamps t, t+6, t+12, t+18; busy_o high 5 of every 6 cycles.
- DEPTH=4, evt_ready_i=0, deadtime_i=0, 6 triggers -> 4 events (trignum 0..3), drop_count_o=2, overflow_o=1; then drain -> trignum 0..3 in order, next trigger gets trignum 4.
- FIFO full, trigger coincident with pop -> trigger dropped, drop_count +1, occupancy 3.
- clear_i coincident with trigger, FIFO holding 2 events -> evt_valid_o 0 next cycle, counters 0, no event pushed.
- enable_i=0 with 3 triggers -> no events, drop_count_o stays 0, busy_o stays 0.
